pll_loop_ctrl: RTL and testbench

Phase detector, PI loop filter and lock detector that closes the digital PLL around the phase-accumulator NCO. On each synchronized rising edge of an external reference, it samples the NCO's phase accumulator and turns it into a signed phase error. A saturating proportional-integral filter converts that error into the NCO's signed `ctrl` trim word. A lock state machine reports loop status.

---
 rtl/pll_pkg.sv | 23 ++
 rtl/sync_edge.sv | 27 ++
 rtl/pll_loop_ctrl.sv | 139 +++++++++++++
 tb/tb_pll_loop_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and helpers for the digital PLL loop controller.
// The saturate helper works on 64-bit signed values. Callers narrow the result to their own width.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLD     = 2'd3
  } lock_state_t;

  // Clamp v to the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a history flop and a registered rising-edge pulse.
// Reusable for any asynchronous level input.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  // The pulse is registered, so rise is high in the third cycle after din is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/pll_loop_ctrl.sv
// Phase detector, saturating PI loop filter and lock detector for the NCO-based PLL.
// Samples flow err (E) -> integ (E+1) -> ctrl (E+2); ctrl_upd marks a new ctrl.
module pll_loop_ctrl
  import pll_pkg::*;
#(
  parameter int ACC_W    = 24,
  parameter int CTRL_W   = 24,
  parameter int INT_W    = 32,
  parameter int KP_SH    = 4,
  parameter int KI_SH    = 10,
  parameter int LOCK_TOL = 4096,
  parameter int LOCK_CNT = 16,
  parameter int REF_TO   = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     ref_in,
  input  logic        [ACC_W-1:0]  phase_acc,
  output logic signed [CTRL_W-1:0] ctrl,
  output logic                     ctrl_upd,
  output logic                     locked,
  output logic        [1:0]        lock_state
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam int TO_W  = $clog2(REF_TO + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT_V = CNT_W'(LOCK_CNT);
  localparam logic [TO_W-1:0]  REF_TO_V   = TO_W'(REF_TO);

  logic                      ref_edge;
  logic                      sample;
  logic signed [ACC_W:0]     err_full;
  logic signed [ACC_W-1:0]   err_now;
  logic signed [ACC_W-1:0]   err_q;
  logic signed [ACC_W-1:0]   err_q2;
  logic signed [INT_W-1:0]   integ;
  logic signed [INT_W-1:0]   integ_next;
  logic signed [CTRL_W-1:0]  ctrl_next;
  logic                      in_tol;
  logic                      v1, v2;
  lock_state_t               state;
  logic [CNT_W-1:0]          cnt;
  logic [TO_W-1:0]           to_cnt;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ref_in),
    .rise  (ref_edge)
  );

  assign sample     = ena & ref_edge;
  assign lock_state = state;

  // Target phase is 0: an NCO running ahead gives a negative error.
  always_comb begin
    err_full   = -$signed({phase_acc[ACC_W-1], phase_acc});
    err_now    = ACC_W'(sat_w(64'(err_full), ACC_W));
    in_tol     = (64'(err_now) <= 64'(LOCK_TOL)) && (64'(err_now) >= -64'(LOCK_TOL));
    integ_next = INT_W'(sat_w(64'(integ) + 64'(err_q), INT_W));
    ctrl_next  = CTRL_W'(sat_w((64'(err_q2) >>> KP_SH) + (64'(integ) >>> KI_SH), CTRL_W));
  end

  // The pipeline stages after E run to completion even if ena drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= '0;
      err_q2   <= '0;
      integ    <= '0;
      ctrl     <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      ctrl_upd <= 1'b0;
    end else begin
      v1 <= sample;
      if (sample) err_q <= err_now;
      v2 <= v1;
      if (v1) begin
        integ  <= integ_next;
        err_q2 <= err_q;
      end
      ctrl_upd <= v2;
      if (v2) ctrl <= ctrl_next;
    end
  end

  // Lock FSM and reference timeout. An accepted edge takes priority over an expiring timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_UNLOCKED;
      cnt    <= '0;
      to_cnt <= '0;
      locked <= 1'b0;
    end else if (sample) begin
      to_cnt <= '0;
      case (state)
        ST_UNLOCKED: begin
          if (in_tol) begin
            state <= ST_ACQUIRE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_ACQUIRE: begin
          if (in_tol) begin
            cnt <= cnt + CNT_W'(1);
            if ((cnt + CNT_W'(1)) == LOCK_CNT_V) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end else begin
            state <= ST_UNLOCKED;
            cnt   <= '0;
          end
        end
        ST_LOCKED: begin
          if (!in_tol) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (in_tol) begin
            state <= ST_LOCKED;
          end else begin
            state  <= ST_UNLOCKED;
            locked <= 1'b0;
            cnt    <= '0;
          end
        end
      endcase
    end else if (ena) begin
      if (to_cnt != REF_TO_V) to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt >= REF_TO_V - TO_W'(1)) begin
        state  <= ST_UNLOCKED;
        cnt    <= '0;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Bench for pll_loop_ctrl: a behavioural PI/lock model feeds an expected-ctrl queue,
// plus a lock-state vector table and hand-written reset, gating and timeout sequences.
module tb_pll_loop_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic               ref_in;
  logic        [23:0] phase_acc;
  logic signed [23:0] ctrl;
  logic               ctrl_upd;
  logic               locked;
  logic        [1:0]  lock_state;

  int checks   = 0;
  int errors   = 0;
  int upd_seen = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_v;

  longint integ_m;
  longint ctrl_m;
  int     st_m;
  int     cnt_m;

  typedef struct {
    logic [23:0] pa;
    logic [1:0]  st;
    logic        lk;
  } vec_t;
  vec_t vecs[19];

  pll_loop_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ref_in     (ref_in),
    .phase_acc  (phase_acc),
    .ctrl       (ctrl),
    .ctrl_upd   (ctrl_upd),
    .locked     (locked),
    .lock_state (lock_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    integ_m = 0;
    ctrl_m  = 0;
    st_m    = 0;
    cnt_m   = 0;
    exp_q.delete();
  endtask

  task automatic model_sample(input logic [23:0] pa);
    longint e;
    bit     tol;
    e       = clamp(-longint'($signed(pa)), 24);
    integ_m = clamp(integ_m + e, 32);
    ctrl_m  = clamp((e >>> 4) + (integ_m >>> 10), 24);
    exp_q.push_back(24'(ctrl_m));
    tol = (e <= 4096) && (e >= -4096);
    case (st_m)
      0: if (tol) begin st_m = 1; cnt_m = 1; end
      1: begin
        if (tol) begin
          cnt_m++;
          if (cnt_m == 16) st_m = 2;
        end else begin
          st_m = 0; cnt_m = 0;
        end
      end
      2: if (!tol) st_m = 3;
      default: begin
        if (tol) st_m = 2;
        else begin st_m = 0; cnt_m = 0; end
      end
    endcase
  endtask

  // One reference pulse: high 2 cycles, low 2 cycles, phase_acc held through the sample cycle.
  task automatic send_pulse(input logic [23:0] pa);
    phase_acc = pa;
    ref_in    = 1'b1;
    repeat (2) tick();
    ref_in    = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_sample(input logic [23:0] pa);
    model_sample(pa);
    send_pulse(pa);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ctrl_upd === 1'b1) begin
      upd_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ctrl_upd_unexpected: got pulse with ctrl=%0d, expected no pulse", ctrl);
      end else begin
        exp_v = exp_q.pop_front();
        if (ctrl !== exp_v) begin
          errors++;
          $display("FAIL ctrl_value: got %0d expected %0d", ctrl, $signed(exp_v));
        end
      end
    end
  end

  initial begin
    int n;
    bit got;
    int base;

    rst_n     = 1'b0;
    ena       = 1'b1;
    ref_in    = 1'b0;
    phase_acc = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_ctrl", $signed(ctrl), 0);
    chk("reset_ctrl_upd", ctrl_upd, 0);
    chk("reset_locked", locked, 0);
    chk("reset_lock_state", lock_state, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_ctrl", $signed(ctrl), 0);
    chk("idle_no_upd", upd_seen, 0);

    // Single sample with latency measured from the ref_in rise
    phase_acc = 24'h000100;
    model_sample(phase_acc);
    ref_in = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      if (n == 2) begin
        #1;
        ref_in = 1'b0;
      end
      @(negedge clk);
      if (ctrl_upd) got = 1'b1;
    end
    chk("ctrl_upd_latency", n, 6);
    tick();
    chk("single_ctrl", $signed(ctrl), -17);
    chk("single_state", lock_state, 1);

    // Lock acquisition and hysteresis table
    vecs[0] = '{24'h100000, 2'd0, 1'b0};
    for (int i = 1; i <= 15; i++) vecs[i] = '{24'h000010, 2'd1, 1'b0};
    vecs[16] = '{24'h000010, 2'd2, 1'b1};
    vecs[17] = '{24'h100000, 2'd3, 1'b1};
    vecs[18] = '{24'h100000, 2'd0, 1'b0};
    for (int i = 0; i < 19; i++) begin
      send_sample(vecs[i].pa);
      chk($sformatf("table_state_%0d", i), lock_state, vecs[i].st);
      chk($sformatf("table_locked_%0d", i), locked, vecs[i].lk);
    end

    // Relock, then gate with ena=0 using out-of-tolerance pulses
    for (int i = 0; i < 16; i++) send_sample(24'h000010);
    chk("relock_locked", locked, 1);
    chk("relock_state", lock_state, st_m);
    ena = 1'b0;
    repeat (4) tick();
    base = upd_seen;
    for (int i = 0; i < 10; i++) send_pulse(24'h400000);
    repeat (20) tick();
    chk("gate_no_upd", upd_seen - base, 0);
    chk("gate_state", lock_state, 2);
    chk("gate_locked", locked, 1);
    chk("gate_ctrl", $signed(ctrl), ctrl_m);
    ena = 1'b1;
    tick();
    send_sample(24'h000010);
    chk("gate_resume_state", lock_state, st_m);

    // Reference timeout: locked must fall exactly REF_TO cycles after the last sample
    for (int k = 1; k <= 65535; k++) begin
      @(posedge clk);
      #1;
      if (k == 65534) chk("timeout_not_early", locked, 1);
    end
    chk("timeout_locked", locked, 0);
    chk("timeout_state", lock_state, 0);
    chk("timeout_ctrl_hold", $signed(ctrl), ctrl_m);
    st_m  = 0;
    cnt_m = 0;

    // Saturation of err and integrator
    for (int i = 0; i < 300; i++) send_sample(24'h800000);
    repeat (4) tick();
    chk("sat_ctrl", $signed(ctrl), 64'h27FFFE);
    chk("sat_state", lock_state, 0);

    // Reset in the middle of a sample
    phase_acc = 24'h000100;
    ref_in    = 1'b1;
    repeat (2) tick();
    ref_in    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midrst_ctrl", $signed(ctrl), 0);
    chk("midrst_ctrl_upd", ctrl_upd, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_state", lock_state, 0);
    base = upd_seen;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("postrst_no_upd", upd_seen - base, 0);
    chk("postrst_ctrl", $signed(ctrl), 0);

    send_sample(24'h000100);
    repeat (4) tick();
    chk("postrst_single_ctrl", $signed(ctrl), -17);
    chk("postrst_single_state", lock_state, 1);

    repeat (10) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
